// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use, mispredict and
// data-memory wait handling, plus saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_rd_wren,
  input  logic             i_ex_is_load,
  input  logic             i_ex_mispred,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_idex_en,
  output logic             o_exmem_en,
  output logic             o_memwb_en,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_exmem_flush,
  output logic             o_memwb_flush,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFlush   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use, mem_stall, eval_ex, mispred_apply;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_fl, idex_fl, exmem_fl, memwb_fl;

  assign load_use = i_ex_is_load & i_ex_rd_wren & (i_ex_rd != 5'd0) &
                    ((i_id_rs1_used & (i_id_rs1 == i_ex_rd)) |
                     (i_id_rs2_used & (i_id_rs2 == i_ex_rd)));
  assign mem_stall = i_mem_req & ~i_mem_ready;

  always_comb begin
    state_d       = state_q;
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    idex_en       = 1'b1;
    exmem_en      = 1'b1;
    memwb_en      = 1'b1;
    ifid_fl       = 1'b0;
    idex_fl       = 1'b0;
    exmem_fl      = 1'b0;
    memwb_fl      = 1'b0;
    eval_ex       = 1'b0;
    mispred_apply = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          // Freeze everything up to MEM; a pending mispredict stays visible in EX.
          {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
          memwb_fl = 1'b1;
          state_d  = StMemWait;
        end else begin
          eval_ex = 1'b1;
        end
      end
      StMemWait: begin
        if (!i_mem_ready) begin
          {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
          memwb_fl = 1'b1;
        end else begin
          eval_ex = 1'b1;
        end
      end
      StFlush: begin
        // Squash the wrong-path fetch issued before the redirect took effect.
        ifid_fl = 1'b1;
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase

    if (eval_ex) begin
      state_d = StRun;
      if (i_ex_mispred) begin
        ifid_fl       = 1'b1;
        idex_fl       = 1'b1;
        mispred_apply = 1'b1;
        state_d       = StFlush;
      end else if (load_use) begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        idex_fl = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (mispred_apply && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= StRun;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Reset overrides the hazard decode so the pipeline registers stay transparent.
  always_comb begin
    o_pc_en       = pc_en | ~i_reset;
    o_ifid_en     = ifid_en | ~i_reset;
    o_idex_en     = idex_en | ~i_reset;
    o_exmem_en    = exmem_en | ~i_reset;
    o_memwb_en    = memwb_en | ~i_reset;
    o_ifid_flush  = ifid_fl & i_reset;
    o_idex_flush  = idex_fl & i_reset;
    o_exmem_flush = exmem_fl & i_reset;
    o_memwb_flush = memwb_fl & i_reset;
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
  assign o_state     = state_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. It drives the enable and flush inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, EX-stage branch mispredictions and multi-cycle data-memory accesses, and keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_id_rs1, i_id_rs2  in  5 each  source register indices of the instruction in ID.
- i_id_rs1_used, i_id_rs2_used  in  1 each  the ID instruction actually reads rs1 / rs2.
- i_ex_rd  in  5  destination register index of the instruction in EX.
- i_ex_rd_wren  in  1  the EX instruction writes rd.
- i_ex_is_load  in  1  the EX instruction is a load.
- i_ex_mispred  in  1  branch/jump in EX resolved as mispredicted.
- i_mem_req  in  1  the MEM-stage instruction performs a data-memory access this cycle.
- i_mem_ready  in  1  data memory completes the access this cycle.
- o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en  out  1 each  register enables (1 = load).
- o_ifid_flush, o_idex_flush, o_exmem_flush, o_memwb_flush  out  1 each  bubble insert (1 = clear).
- o_stall_cnt  out  CNT_W  cycles with o_pc_en=0.
- o_flush_cnt  out  CNT_W  mispredict events applied.
- o_state  out  2  current FSM state (RUN=0, MEM_WAIT=1, FLUSH=2).

## Operation
- Load-use hazard (LU) = i_ex_is_load & i_ex_rd_wren & (i_ex_rd != 0) & ((i_id_rs1_used & i_id_rs1 == i_ex_rd) | (i_id_rs2_used & i_id_rs2 == i_ex_rd)).
- Memory stall (MS) = i_mem_req & !i_mem_ready.
- Default (no event): all enables 1, all flushes 0.
- States:
  - RUN:
    - If MS: pc/ifid/idex/exmem enables 0, o_memwb_flush=1; next state MEM_WAIT. MS has top priority; a concurrent mispredict is deferred because EX is frozen and i_ex_mispred stays asserted.
    - Else if i_ex_mispred: o_ifid_flush=1, o_idex_flush=1; o_flush_cnt+1; next state FLUSH.
    - Else if LU: o_pc_en=0, o_ifid_en=0, o_idex_flush=1 (one bubble); stay in RUN.
    - Otherwise: default outputs; stay in RUN.
  - MEM_WAIT:
    - If !i_mem_ready: same outputs as MS; i_ex_mispred and LU ignored.
    - If i_mem_ready: all enables 1, no MEM flush. Then i_ex_mispred, then LU, are evaluated exactly as in RUN. Next state is FLUSH if a mispredict was applied, else RUN.
  - FLUSH: exactly one cycle. o_ifid_flush=1 squashes the wrong-path fetch caused by the 1-cycle redirect latency; other outputs default. Next state RUN. i_ex_mispred in this cycle belongs to a wrong-path slot already flushed and is ignored.
- A flush output to a register always has priority over that register's enable.
- Counters: o_stall_cnt +1 on every cycle with o_pc_en=0; o_flush_cnt +1 on every cycle a mispredict is applied. Both saturate at all-ones and never wrap.

## Timing
- Control outputs are combinational (Mealy) from state and inputs: zero-cycle latency from hazard input to enable/flush.
- State and counters update on posedge i_clk.
- Reset (i_reset=0, asynchronous): state=RUN, o_state=0, counters=0. While reset is held, all enables are forced 1 and all flushes forced 0.
- Reset asserted mid-MEM_WAIT or mid-FLUSH aborts the sequence immediately. On release, operation resumes in RUN.
- Load-use costs exactly 1 stall cycle. A mispredict costs 2 flushed fetch slots (cycle of detection plus the FLUSH cycle). A memory access costs N stall cycles, where N = cycles with i_mem_ready=0.

## Test plan
- Load-use: EX lw x5 (rd=5, is_load=1), ID add x6,x5,x1 (rs1=5, used) -> 1 cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1; state stays 0. Same with rd=0 -> no stall.
- Mispredict: i_ex_mispred=1 for one cycle in RUN -> ifid_flush=idex_flush=1 that cycle, ifid_flush=1 next cycle (o_state=2), then RUN; flush_cnt=1.
- Memory wait: i_mem_req=1, i_mem_ready=0 for 3 cycles then 1 -> 3 cycles with pc/ifid/idex/exmem_en=0 and memwb_flush=1, release on 4th cycle; stall_cnt=3.
- Simultaneous events: MS + i_ex_mispred held -> MEM_WAIT first, mispredict applied in the ready cycle, then FLUSH; flush_cnt=1. Separately, LU + mispredict in RUN -> mispredict flush only, pc_en stays 1.
- Reset: assert i_reset=0 during MEM_WAIT after 2 stall cycles -> o_state=0, counters 0, all enables 1 immediately and asynchronously.
- Saturation: preload o_stall_cnt to 0xFFFFFFFE via force, apply 3 load-use stalls -> counter reads 0xFFFFFFFF and holds.
